// File: rtl/wb_dmem_arbiter.sv
// Two-master / one-slave Wishbone B4 classic arbiter for the SoC data memory.
// Master 0 is the core data port, master 1 is the debug/DMA/loader port.
// Round-robin on ties, grant locked for the whole CYC, optional bus timeout.
module wb_dmem_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    // master 0
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    // master 1
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    // slave
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    // status
    output logic            grant_o,
    output logic            busy_o
);

    localparam int unsigned SW = DW / 8;
    // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]    r_state;
    logic          r_grant;
    logic          r_last;
    logic [TW-1:0] r_tmo_cnt;

    logic [0:0]    w_state_nxt;
    logic          w_grant_nxt;
    logic          w_last_nxt;
    logic [TW-1:0] w_tmo_cnt_nxt;

    logic          w_busy;
    logic          w_force_err;
    logic          w_cyc;
    logic          w_stb;
    logic          w_we;
    logic [AW-1:0] w_adr;
    logic [DW-1:0] w_dat;
    logic [SW-1:0] w_sel;

    assign w_busy      = (r_state == ST_BUSY);
    assign w_force_err = (TIMEOUT != 0) && w_busy && (r_tmo_cnt == TMO_MAX);

    // Select the request signals of the current owner.
    always_comb begin
        if (r_grant) begin
            w_cyc = m1_cyc_i;
            w_stb = m1_stb_i;
            w_we  = m1_we_i;
            w_adr = m1_adr_i;
            w_dat = m1_dat_i;
            w_sel = m1_sel_i;
        end else begin
            w_cyc = m0_cyc_i;
            w_stb = m0_stb_i;
            w_we  = m0_we_i;
            w_adr = m0_adr_i;
            w_dat = m0_dat_i;
            w_sel = m0_sel_i;
        end
    end

    // Drive the slave bus and route termination back to the owner only.
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        if (w_busy) begin
            s_cyc_o = w_cyc;
            s_stb_o = w_stb & ~w_force_err;
            s_we_o  = w_we;
            s_adr_o = w_adr;
            s_dat_o = w_dat;
            s_sel_o = w_sel;
            if (r_grant) begin
                m1_ack_o = s_ack_i & ~w_force_err;
                m1_err_o = s_err_i | w_force_err;
            end else begin
                m0_ack_o = s_ack_i & ~w_force_err;
                m0_err_o = s_err_i | w_force_err;
            end
        end
    end

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign grant_o  = r_grant;
    assign busy_o   = w_busy;

    // Arbitration in IDLE, release when the owner drops CYC.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        if (r_state == ST_IDLE) begin
            if (m0_cyc_i || m1_cyc_i) begin
                w_state_nxt = ST_BUSY;
                // On a tie the master not served last wins.
                w_grant_nxt = (m0_cyc_i && m1_cyc_i) ? ~r_last : m1_cyc_i;
            end
        end else if (!w_cyc) begin
            w_state_nxt = ST_IDLE;
            w_last_nxt  = r_grant;
        end
    end

    // Count cycles a strobe waits unanswered; clears on any termination.
    always_comb begin
        if ((TIMEOUT == 0) || !w_busy || !s_stb_o || s_ack_i || s_err_i) begin
            w_tmo_cnt_nxt = '0;
        end else begin
            w_tmo_cnt_nxt = r_tmo_cnt + TW'(1);
        end
    end

    // State registers; last=1 so master 0 wins the first tie after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_grant   <= 1'b0;
            r_last    <= 1'b1;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_last    <= w_last_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_wb_dmem_arbiter.sv
// Self-checking bench for wb_dmem_arbiter: per-cycle vector table plus
// hand-written timeout and mid-cycle reset sequences.
module tb_wb_dmem_arbiter;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } bus_t;

    typedef struct {
        logic        rst;
        bus_t        m0;
        bus_t        m1;
        logic [31:0] sdat;
        logic        sack;
        logic        serr;
        bus_t        es;     // expected slave bus
        logic [3:0]  eterm;  // {m0_ack, m0_err, m1_ack, m1_err}
        logic        egrant;
        logic        ebusy;
    } vec_t;

    localparam int NV = 30;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat_i;
    logic [3:0] m0_sel, m1_sel;
    logic s_ack_i, s_err_i;

    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
    logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic s_cyc_o, s_stb_o, s_we_o, grant_o, busy_o;
    logic [3:0] s_sel_o;

    logic [31:0] n_m0_dat_o, n_m1_dat_o, n_s_adr_o, n_s_dat_o;
    logic n_m0_ack_o, n_m0_err_o, n_m1_ack_o, n_m1_err_o;
    logic n_s_cyc_o, n_s_stb_o, n_s_we_o, n_grant_o, n_busy_o;
    logic [3:0] n_s_sel_o;

    int n_cmp = 0;
    int n_err = 0;
    vec_t tbl[NV];

    always #5 clk = ~clk;

    wb_dmem_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i), .grant_o(grant_o), .busy_o(busy_o)
    );

    // Same stimulus, timeout disabled.
    wb_dmem_arbiter #(.AW(32), .DW(32), .TIMEOUT(0)) u_notmo (
        .clk(clk), .reset_n(reset_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_dat_o(n_m0_dat_o), .m0_ack_o(n_m0_ack_o),
        .m0_err_o(n_m0_err_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_dat_o(n_m1_dat_o), .m1_ack_o(n_m1_ack_o),
        .m1_err_o(n_m1_err_o),
        .s_cyc_o(n_s_cyc_o), .s_stb_o(n_s_stb_o), .s_we_o(n_s_we_o), .s_adr_o(n_s_adr_o),
        .s_dat_o(n_s_dat_o), .s_sel_o(n_s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .s_err_i(s_err_i), .grant_o(n_grant_o), .busy_o(n_busy_o)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic bus_t off(input bus_t b);
        bus_t r;
        r = b;
        r.cyc = 1'b0;
        r.stb = 1'b0;
        return r;
    endfunction

    function automatic vec_t mk(input logic rst, input bus_t m0, input bus_t m1,
                                input logic [31:0] sdat, input logic sack, input logic serr,
                                input bus_t es, input logic [3:0] eterm,
                                input logic egrant, input logic ebusy);
        vec_t v;
        v.rst = rst; v.m0 = m0; v.m1 = m1; v.sdat = sdat; v.sack = sack; v.serr = serr;
        v.es = es; v.eterm = eterm; v.egrant = egrant; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic drive(input bus_t a, input bus_t b, input logic [31:0] sd,
                         input logic ack, input logic err);
        {m0_cyc, m0_stb, m0_we, m0_adr, m0_dat, m0_sel} = a;
        {m1_cyc, m1_stb, m1_we, m1_adr, m1_dat, m1_sel} = b;
        s_dat_i = sd;
        s_ack_i = ack;
        s_err_i = err;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        drive('0, '0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bus_t z, w, r0, r1, e1, bk, bgap, sbus;
        z    = '0;
        w    = '{1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF};
        r0   = '{1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'hF};
        r1   = '{1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h1111_2222, 4'h3};
        e1   = '{1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF};
        bgap = '{1'b1, 1'b0, 1'b1, 32'h0000_002C, 32'hC0DE_0003, 4'hF};

        // Single master write, ack one cycle after STB, release.
        tbl[0]  = mk(1, w,  z, 32'h0, 0, 0, z,  4'b0000, 0, 0);
        tbl[1]  = mk(0, w,  z, 32'h0, 0, 0, w,  4'b0000, 0, 1);
        tbl[2]  = mk(0, w,  z, 32'h0, 1, 0, w,  4'b1000, 0, 1);
        tbl[3]  = mk(0, z,  z, 32'h0, 0, 0, z,  4'b0000, 0, 1);
        tbl[4]  = mk(0, z,  z, 32'h0, 0, 0, z,  4'b0000, 0, 0);
        // Tie after reset: m0 first, one IDLE gap, then m1, next tie m0 again.
        tbl[5]  = mk(1, r0, r1, 32'hA5A5_A5A5, 0, 0, z, 4'b0000, 0, 0);
        tbl[6]  = mk(0, r0, r1, 32'hA5A5_A5A5, 1, 0, r0, 4'b1000, 0, 1);
        tbl[7]  = mk(0, off(r0), r1, 32'hA5A5_A5A5, 0, 0, off(r0), 4'b0000, 0, 1);
        tbl[8]  = mk(0, z,  r1, 32'hA5A5_A5A5, 0, 0, z,  4'b0000, 0, 0);
        tbl[9]  = mk(0, z,  r1, 32'h1234_5678, 1, 0, r1, 4'b0010, 1, 1);
        tbl[10] = mk(0, z,  off(r1), 32'h0, 0, 0, off(r1), 4'b0000, 1, 1);
        tbl[11] = mk(0, r0, r1, 32'h0, 0, 0, z,  4'b0000, 1, 0);
        tbl[12] = mk(0, r0, r1, 32'h0, 0, 0, r0, 4'b0000, 0, 1);
        tbl[13] = mk(0, off(r0), r1, 32'h0, 0, 0, off(r0), 4'b0000, 0, 1);
        // Locked m1 burst while m0 waits.
        tbl[14] = mk(0, r0, r1, 32'h0, 0, 0, z,  4'b0000, 0, 0);
        for (int k = 0; k < 4; k++) begin
            bk = '{1'b1, 1'b1, 1'b1, 32'h20 + 32'(4 * k), 32'hC0DE_0000 + 32'(k), 4'hF};
            tbl[15+k] = mk(0, r0, bk, 32'h0, 1, 0, bk, 4'b0010, 1, 1);
        end
        tbl[19] = mk(0, r0, bgap, 32'h0, 0, 0, bgap, 4'b0000, 1, 1);
        tbl[20] = mk(0, r0, z, 32'h0, 0, 0, z, 4'b0000, 1, 1);
        tbl[21] = mk(0, r0, z, 32'h0, 0, 0, z, 4'b0000, 1, 0);
        tbl[22] = mk(0, r0, z, 32'h5A5A_5A5A, 1, 0, r0, 4'b1000, 0, 1);
        tbl[23] = mk(0, z,  z, 32'h0, 0, 0, z, 4'b0000, 0, 1);
        // Stale ACK/ERR in IDLE is dropped.
        tbl[24] = mk(0, z,  z, 32'h0, 1, 1, z, 4'b0000, 0, 0);
        // Slave error on m1, then ACK+ERR together.
        tbl[25] = mk(1, z,  e1, 32'h0, 0, 0, z,  4'b0000, 0, 0);
        tbl[26] = mk(0, z,  e1, 32'h0, 0, 1, e1, 4'b0001, 1, 1);
        tbl[27] = mk(0, z,  e1, 32'h0, 1, 1, e1, 4'b0011, 1, 1);
        tbl[28] = mk(0, z,  z,  32'h0, 0, 0, z,  4'b0000, 1, 1);
        tbl[29] = mk(0, z,  z,  32'h0, 0, 0, z,  4'b0000, 1, 0);

        drive('0, '0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < NV; i++) begin
            if (tbl[i].rst) do_reset();
            else @(negedge clk);
            drive(tbl[i].m0, tbl[i].m1, tbl[i].sdat, tbl[i].sack, tbl[i].serr);
            #1;
            sbus = '{s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o};
            chk($sformatf("row%0d slave_bus", i), 72'(sbus), 72'(tbl[i].es));
            chk($sformatf("row%0d term", i), 72'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}),
                72'(tbl[i].eterm));
            chk($sformatf("row%0d grant_busy", i), 72'({grant_o, busy_o}),
                72'({tbl[i].egrant, tbl[i].ebusy}));
            chk($sformatf("row%0d rdata", i), 72'({m0_dat_o, m1_dat_o}),
                72'({tbl[i].sdat, tbl[i].sdat}));
        end

        // Timeout: ERR exactly 8 cycles after STB first reaches the slave.
        do_reset();
        drive('{1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 4'hF}, '0, 32'h0, 1'b0, 1'b0);
        #1;
        chk("tmo idle_stb", 72'(s_stb_o), 72'(0));
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            #1;
            if (c <= 9) begin
                chk($sformatf("tmo c%0d err", c), 72'(m0_err_o), 72'(c == 8));
                chk($sformatf("tmo c%0d stb", c), 72'(s_stb_o), 72'(c != 8));
                chk($sformatf("tmo c%0d ack", c), 72'(m0_ack_o), 72'(0));
            end
            chk($sformatf("notmo c%0d err_stb", c), 72'({n_m0_err_o, n_s_stb_o, n_busy_o}),
                72'(3'b011));
        end
        @(negedge clk);
        drive('0, '0, 32'h0, 1'b0, 1'b0);

        // Reset mid-cycle with m1 owning the bus.
        do_reset();
        drive('0, e1, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        chk("rst pre_cyc", 72'({s_cyc_o, s_stb_o, grant_o}), 72'(3'b111));
        #2;
        reset_n = 1'b0;
        s_ack_i = 1'b1;
        #1;
        chk("rst async_drop", 72'({s_cyc_o, s_stb_o, busy_o}), 72'(3'b000));
        chk("rst no_ack", 72'({m0_ack_o, m1_ack_o}), 72'(2'b00));
        drive(r0, e1, 32'h0, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        s_ack_i = 1'b0;
        #1;
        chk("rst release_idle", 72'({busy_o, s_cyc_o}), 72'(2'b00));
        @(negedge clk);
        #1;
        chk("rst tie_grant", 72'({busy_o, grant_o}), 72'(2'b10));
        chk("rst tie_adr", 72'(s_adr_o), 72'(32'h100));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_dmem_arbiter.md
Name: wb_dmem_arbiter

Overview:
- Two-master, one-slave Wishbone B4 classic arbiter that shares the SoC data memory (data_mem_inst) between the core data port (master 0) and a second requester (master 1: debug/DMA/loader).
- Sits between the processor core's dmem Wishbone port and data_mem_inst.
- Provides round-robin arbitration and whole-cycle locking (grant held while granted CYC is high).
- Provides a bus timeout that returns ERR to a master whose slave never acknowledges.

Parameters:
- AW, 32, address width.
- DW, 32, data width; SEL width is DW/8.
- TIMEOUT, 255, max cycles STB may wait for ACK/ERR before the arbiter forces ERR; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 Wishbone controls
- m0_adr_i  in  AW  master 0 address
- m0_dat_i  in  DW  master 0 write data
- m0_sel_i  in  DW/8  master 0 byte selects
- m0_dat_o  out  DW  read data to master 0
- m0_ack_o, m0_err_o  out  1 each  cycle termination to master 0
- m1_*  same set as m0_*, for master 1
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave
- s_adr_o  out  AW  to slave
- s_dat_o  out  DW  to slave
- s_sel_o  out  DW/8  to slave
- s_dat_i  in  DW  slave read data
- s_ack_i, s_err_i  in  1 each  slave termination
- grant_o  out  1  current owner (0/1); meaningful only while busy_o=1
- busy_o  out  1  a master currently holds the bus

Behaviour:
- State register: IDLE, BUSY. Registers: grant (1b), last (1b, last master served), tmo_cnt (clog2(TIMEOUT+1) bits).
- Reset values: state=IDLE, grant=0, last=1 (master 0 wins the first tie), tmo_cnt=0.
- Output reset values: all s_* outputs 0, all m*_ack_o/m*_err_o 0, busy_o=0, grant_o=0, m*_dat_o = s_dat_i (pass-through).
- IDLE: arbitrates on m0_cyc_i/m1_cyc_i.
  - Only one CYC high: grant that master.
  - Both high: grant !last.
  - Neither high: stay IDLE.
  - Grant takes effect at the next clk edge; state moves to BUSY.
  - Arbitration latency is exactly 1 cycle from request to slave CYC.
- BUSY, slave side:
  - s_cyc_o = m[grant]_cyc_i.
  - s_stb_o = m[grant]_stb_i & ~force_err.
  - s_we/adr/dat/sel are muxed combinationally from m[grant].
  - All s_* are 0 in IDLE.
- BUSY, master side:
  - m[grant]_ack_o = s_ack_i & ~force_err.
  - m[grant]_err_o = s_err_i | force_err.
  - Non-granted master: ack=err=0; it stalls with no timeout of its own.
- Grant release:
  - Held for as long as m[grant]_cyc_i stays 1, so bursts and read-modify-write are never split.
  - When m[grant]_cyc_i=0 in BUSY: state moves to IDLE and last<=grant at the next edge.
  - Re-arbitration happens in IDLE the following cycle. A master dropping and immediately re-raising CYC loses to a waiting peer.
- Timeout:
  - tmo_cnt clears whenever s_stb_o=0, or s_ack_i/s_err_i=1, or state=IDLE.
  - Otherwise it increments by 1 per cycle.
  - force_err = (TIMEOUT!=0) && (tmo_cnt==TIMEOUT). This is a single-cycle ERR to the granted master; the slave STB is masked that cycle and tmo_cnt then clears.
  - The master must drop STB/CYC after ERR; grant releases per the normal rule.
- s_ack_i and s_err_i asserted together: both are forwarded. A slave asserting both is a protocol violation; the arbiter takes no further action.
- Reset asserted mid-transaction: s_cyc_o/s_stb_o fall immediately (asynchronously) and the in-flight cycle is abandoned with no ACK. After release, the arbiter starts in IDLE with last=1.
- ACK/ERR arriving in IDLE (stale): ignored and not forwarded.

Test Plan:
- Single master:
  - Stimulus: m0 writes 0xDEADBEEF to adr 0x0000_0010, sel=0xF; slave acks 1 cycle after STB.
  - Required: s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o pulses 1 cycle; busy_o falls the cycle after m0 drops CYC.
- Simultaneous request after reset:
  - Stimulus: m0 and m1 raise CYC in the same cycle.
  - Required: m0 is served first (grant_o=0). Then m1 (grant_o=1) after m0 drops CYC, with 1 IDLE cycle between.
  - Next tie: m0 wins again (last=1).
- Locked burst:
  - Stimulus: m1 holds CYC across 4 STB/ACK beats (adr 0x20..0x2C) while m0 requests.
  - Required: m0_ack_o stays 0 throughout; m0 is granted only after m1 drops CYC.
- Timeout:
  - Stimulus: TIMEOUT=8; m0 reads, slave never acks.
  - Required: m0_err_o=1 for exactly one cycle, 8 cycles after s_stb_o first rises; s_stb_o=0 in that cycle.
  - Variant with TIMEOUT=0: m0 remains stalled indefinitely.
- Slave error pass-through:
  - Stimulus: slave asserts s_err_i on an m1 access.
  - Required: m1_err_o=1 in the same cycle; m0_err_o=0; tmo_cnt clears.
- Reset mid-cycle:
  - Stimulus: drop reset_n while m1 is granted and STB is high.
  - Required: s_cyc_o=0 immediately and no ACK is delivered.
  - After release with both masters requesting: m0 is granted first.
